// File: rtl/elu_lut_loader_if.sv
// Host byte stream in, LUT RAM write port out; master side is the loader.
// Combinational bundle, no latency; s_valid/s_ready handshake on the stream.
interface elu_lut_loader_if #(
  parameter int ADDR_W = 10,
  parameter int QZ_D   = 16
) ();
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [QZ_D-1:0]   wr_data;

  modport master (
    input  s_data, s_valid,
    output s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/elu_lut_loader.sv
// Assembles LE byte pairs into LUT words, writes them one cycle after the high byte,
// then checks a trailing 16-bit additive checksum; s_ready is high only while loading.
module elu_lut_loader #(
  parameter int QZ_D        = 16,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int TO_W        = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  elu_lut_loader_if.master   bus,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               lut_valid
);

  typedef enum logic [2:0] {
    IDLE,
    RX_LO,
    RX_HI,
    CHK_LO,
    CHK_HI,
    DONE,
    ERR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam bit                TO_EN     = (TIMEOUT_CYC != 0);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;

  state_t            state;
  logic [7:0]        lo_byte;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       csum;
  logic [TO_W-1:0]   to_cnt;

  logic              hs;
  logic [15:0]       rx_word;
  logic              to_hit;

  assign hs      = bus.s_valid & bus.s_ready;
  assign rx_word = {bus.s_data, lo_byte};
  // s_ready doubles as the "in a receive state" flag, so the timeout only runs while loading
  assign to_hit  = TO_EN && bus.s_ready && !hs && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lo_byte     <= '0;
      addr        <= '0;
      csum        <= '0;
      to_cnt      <= '0;
      bus.s_ready <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      lut_valid   <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      done      <= 1'b0;

      if (bus.s_ready) begin
        if (hs) to_cnt <= '0;
        else    to_cnt <= to_cnt + 1'b1;
      end

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state       <= RX_LO;
            bus.s_ready <= 1'b1;
            busy        <= 1'b1;
            err         <= 1'b0;
            lut_valid   <= 1'b0;
            addr        <= '0;
            csum        <= '0;
            to_cnt      <= '0;
          end
        end

        RX_LO: begin
          if (hs) begin
            lo_byte <= bus.s_data;
            state   <= RX_HI;
          end
        end

        RX_HI: begin
          if (hs) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= addr;
            bus.wr_data <= QZ_D'(rx_word);
            csum        <= csum + rx_word;
            // hold the address at the last entry rather than wrapping to 0
            if (addr == LAST_ADDR) begin
              state <= CHK_LO;
            end else begin
              addr  <= addr + 1'b1;
              state <= RX_LO;
            end
          end
        end

        CHK_LO: begin
          if (hs) begin
            lo_byte <= bus.s_data;
            state   <= CHK_HI;
          end
        end

        CHK_HI: begin
          if (hs) begin
            bus.s_ready <= 1'b0;
            busy        <= 1'b0;
            if (rx_word == csum) begin
              state     <= DONE;
              done      <= 1'b1;
              lut_valid <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase

      if (to_hit) begin
        state       <= ERR;
        err         <= 1'b1;
        busy        <= 1'b0;
        bus.s_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_elu_lut_loader.sv
// Bench for elu_lut_loader: three instances (1024/65535, 4/100, 4/50) share one stream driver;
// a word-level model predicts the write list and load outcome.
module tb_elu_lut_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [7:0] s_data;
  logic       s_valid;
  int         sel;

  logic start_a, start_b, start_c;
  logic busy_a, done_a, err_a, lv_a;
  logic busy_b, done_b, err_b, lv_b;
  logic busy_c, done_c, err_c, lv_c;

  elu_lut_loader_if #(.ADDR_W(10), .QZ_D(16)) ifa ();
  elu_lut_loader_if #(.ADDR_W(10), .QZ_D(16)) ifb ();
  elu_lut_loader_if #(.ADDR_W(10), .QZ_D(16)) ifc ();

  assign ifa.s_data  = s_data;
  assign ifa.s_valid = s_valid;
  assign ifb.s_data  = s_data;
  assign ifb.s_valid = s_valid;
  assign ifc.s_data  = s_data;
  assign ifc.s_valid = s_valid;

  assign start_a = start & (sel == 0);
  assign start_b = start & (sel == 1);
  assign start_c = start & (sel == 2);

  elu_lut_loader #(.QZ_D(16), .ADDR_W(10), .DEPTH(1024), .TO_W(16), .TIMEOUT_CYC(65535)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(ifa),
    .busy(busy_a), .done(done_a), .err(err_a), .lut_valid(lv_a)
  );
  elu_lut_loader #(.QZ_D(16), .ADDR_W(10), .DEPTH(4), .TO_W(16), .TIMEOUT_CYC(100)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(ifb),
    .busy(busy_b), .done(done_b), .err(err_b), .lut_valid(lv_b)
  );
  elu_lut_loader #(.QZ_D(16), .ADDR_W(10), .DEPTH(4), .TO_W(16), .TIMEOUT_CYC(50)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .bus(ifc),
    .busy(busy_c), .done(done_c), .err(err_c), .lut_valid(lv_c)
  );

  logic       cur_s_ready, cur_wr_en, cur_busy, cur_done, cur_err, cur_lv;
  logic [9:0] cur_wr_addr;
  logic [15:0] cur_wr_data;

  always_comb begin
    cur_s_ready = ifa.s_ready; cur_wr_en = ifa.wr_en; cur_wr_addr = ifa.wr_addr;
    cur_wr_data = ifa.wr_data; cur_busy = busy_a; cur_done = done_a;
    cur_err = err_a; cur_lv = lv_a;
    if (sel == 1) begin
      cur_s_ready = ifb.s_ready; cur_wr_en = ifb.wr_en; cur_wr_addr = ifb.wr_addr;
      cur_wr_data = ifb.wr_data; cur_busy = busy_b; cur_done = done_b;
      cur_err = err_b; cur_lv = lv_b;
    end else if (sel == 2) begin
      cur_s_ready = ifc.s_ready; cur_wr_en = ifc.wr_en; cur_wr_addr = ifc.wr_addr;
      cur_wr_data = ifc.wr_data; cur_busy = busy_c; cur_done = done_c;
      cur_err = err_c; cur_lv = lv_c;
    end
  end

  typedef struct packed {
    logic [9:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  done_cnt;
  int  rdy_viol;
  int  stalls;
  int  vectors;
  int  miscompares;

  // Observed side: every write strobe, done pulse and ready/busy disagreement of the selected DUT
  always @(negedge clk) begin
    if (cur_wr_en === 1'b1) obs_q.push_back({cur_wr_addr, cur_wr_data});
    if (cur_done === 1'b1) done_cnt++;
    if (cur_s_ready !== cur_busy) rdy_viol++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    bit taken;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    taken = 1'b0;
    s_valid = 1'b0;
    repeat (g) begin
      s_data = 8'($urandom);
      @(negedge clk);
    end
    s_data  = b;
    s_valid = 1'b1;
    for (int t = 0; t < 300 && !taken; t++) begin
      if (cur_s_ready === 1'b1) taken = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    if (!taken) stalls++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [15:0] make_word(input int pattern, input int i);
    case (pattern)
      0:       return 16'(i * 3);
      1:       return 16'(i + 1);
      default: return 16'($urandom);
    endcase
  endfunction

  // Model: words i land at addr i in order; load passes iff the sent sum equals sum(words) mod 2^16
  task automatic do_load(input string name, input int nwords, input int pattern, input int max_gap,
                         input int csum_mode, input logic [15:0] csum_fixed, input int mid_start);
    logic [15:0] w, sum, sent;
    sum = '0;
    exp_q.delete();
    obs_q.delete();
    done_cnt = 0; rdy_viol = 0; stalls = 0;
    pulse_start();
    check({name, ".start_busy"}, cur_busy, 1);
    check({name, ".start_err"}, cur_err, 0);
    check({name, ".start_lut_valid"}, cur_lv, 0);
    for (int i = 0; i < nwords; i++) begin
      w = make_word(pattern, i);
      exp_q.push_back('{a: 10'(i), d: w});
      sum = sum + w;
      if (i == mid_start) pulse_start();
      send_byte(w[7:0], max_gap);
      send_byte(w[15:8], max_gap);
    end
    case (csum_mode)
      0:       sent = sum;
      1:       sent = sum ^ 16'h0100;
      default: sent = csum_fixed;
    endcase
    send_byte(sent[7:0], max_gap);
    send_byte(sent[15:8], max_gap);
    repeat (3) @(negedge clk);
  endtask

  task automatic finish_checks(input string name, input bit exp_ok);
    int mism;
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) mism++;
    check({name, ".nwrites"}, obs_q.size(), exp_q.size());
    check({name, ".write_mismatches"}, mism, 0);
    check({name, ".done_pulses"}, done_cnt, exp_ok ? 1 : 0);
    check({name, ".err"}, cur_err, !exp_ok);
    check({name, ".lut_valid"}, cur_lv, exp_ok);
    check({name, ".busy_after"}, cur_busy, 0);
    check({name, ".ready_vs_busy"}, rdy_viol, 0);
    check({name, ".stalls"}, stalls, 0);
  endtask

  typedef struct {
    int          dut;
    int          nwords;
    int          pattern;
    int          max_gap;
    int          csum_mode;
    logic [15:0] csum_fixed;
    int          mid_start;
    bit          exp_ok;
    string       name;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n;
    logic [15:0] w;

    tbl[0] = '{0, 1024, 0, 0,  2, 16'hFA00, -1, 1'b1, "full1024"};
    tbl[1] = '{1, 4,    1, 0,  2, 16'h000B, -1, 1'b0, "badsum"};
    tbl[2] = '{1, 4,    1, 20, 2, 16'h000A, -1, 1'b1, "gaps"};
    tbl[3] = '{1, 4,    2, 20, 0, 16'h0000, -1, 1'b1, "rand_ok"};
    tbl[4] = '{1, 4,    2, 3,  1, 16'h0000, -1, 1'b0, "rand_bad"};
    tbl[5] = '{2, 4,    2, 20, 0, 16'h0000, -1, 1'b1, "rand_to50"};
    tbl[6] = '{1, 4,    1, 0,  2, 16'h000A, 2,  1'b1, "start_mid"};
    tbl[7] = '{1, 4,    2, 0,  0, 16'h0000, -1, 1'b1, "after_done"};

    vectors = 0; miscompares = 0;
    done_cnt = 0; rdy_viol = 0; stalls = 0;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; sel = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      check($sformatf("reset.outputs%0d", d),
            {cur_s_ready, cur_wr_en, cur_wr_addr, cur_wr_data, cur_busy, cur_done, cur_err, cur_lv}, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      sel = tbl[k].dut;
      @(negedge clk);
      do_load(tbl[k].name, tbl[k].nwords, tbl[k].pattern, tbl[k].max_gap,
              tbl[k].csum_mode, tbl[k].csum_fixed, tbl[k].mid_start);
      finish_checks(tbl[k].name, tbl[k].exp_ok);
    end

    // Timeout: 5 bytes then silence on the 50-cycle instance
    sel = 2;
    @(negedge clk);
    exp_q.delete(); obs_q.delete();
    done_cnt = 0; rdy_viol = 0; stalls = 0;
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      w = 16'($urandom);
      exp_q.push_back('{a: 10'(i), d: w});
      send_byte(w[7:0], 0);
      send_byte(w[15:8], 0);
    end
    send_byte(8'($urandom), 0);
    n = 0;
    while (cur_err !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout.cycles", n, 50);
    check("timeout.s_ready", cur_s_ready, 0);
    repeat (3) @(negedge clk);
    finish_checks("timeout", 1'b0);

    // Reset in the middle of a 1024-word load, then a full reload
    sel = 0;
    @(negedge clk);
    obs_q.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      w = 16'($urandom);
      send_byte(w[7:0], 0);
      send_byte(w[15:8], 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst.outputs",
          {cur_s_ready, cur_wr_en, cur_wr_addr, cur_wr_data, cur_busy, cur_done, cur_err, cur_lv}, 0);
    rst = 1'b0;
    obs_q.delete();
    s_valid = 1'b1;
    repeat (5) @(negedge clk);
    s_valid = 1'b0;
    check("rst.no_writes", obs_q.size(), 0);
    check("rst.lut_valid", cur_lv, 0);
    do_load("reload", 1024, 2, 0, 0, 16'h0000, -1);
    finish_checks("reload", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
